// File: rtl/axi_tdd_ng_channel_gen_if.sv
// Frame-counter state encoding and the channel generator's bus interface.
//
// axi_tdd_ng_pkg::state_t : TDD counter state (IDLE/ARMED/WAITING/RUNNING).
//
// axi_tdd_ng_channel_gen_if groups the signals exchanged with the channel
// generator:
//   tdd_enable       global enable
//   tdd_cstate       counter state
//   tdd_counter      frame position
//   tdd_endof_frame  last count of the frame
//   tdd_channel_en   per-channel enable
//   tdd_channel_pol  per-channel polarity (1 = inverted)
//   tdd_channel_on   packed ON counts, channel i at [i*REGISTER_WIDTH +: REGISTER_WIDTH]
//   tdd_channel_off  packed OFF counts, same packing
//   tdd_channel      channel outputs
//   tdd_channel_rise active-bit rising pulses
//   tdd_channel_fall active-bit falling pulses
// modport master : the side that drives counter/config and reads the outputs.
// modport slave  : the channel generator.

package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

endpackage

interface axi_tdd_ng_channel_gen_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_CHANNELS   = 8
);

  import axi_tdd_ng_pkg::*;

  logic                                   tdd_enable;
  state_t                                 tdd_cstate;
  logic [REGISTER_WIDTH-1:0]              tdd_counter;
  logic                                   tdd_endof_frame;
  logic [NUM_CHANNELS-1:0]                tdd_channel_en;
  logic [NUM_CHANNELS-1:0]                tdd_channel_pol;
  logic [NUM_CHANNELS*REGISTER_WIDTH-1:0] tdd_channel_on;
  logic [NUM_CHANNELS*REGISTER_WIDTH-1:0] tdd_channel_off;
  logic [NUM_CHANNELS-1:0]                tdd_channel;
  logic [NUM_CHANNELS-1:0]                tdd_channel_rise;
  logic [NUM_CHANNELS-1:0]                tdd_channel_fall;

  modport master (
    output tdd_enable,
    output tdd_cstate,
    output tdd_counter,
    output tdd_endof_frame,
    output tdd_channel_en,
    output tdd_channel_pol,
    output tdd_channel_on,
    output tdd_channel_off,
    input  tdd_channel,
    input  tdd_channel_rise,
    input  tdd_channel_fall
  );

  modport slave (
    input  tdd_enable,
    input  tdd_cstate,
    input  tdd_counter,
    input  tdd_endof_frame,
    input  tdd_channel_en,
    input  tdd_channel_pol,
    input  tdd_channel_on,
    input  tdd_channel_off,
    output tdd_channel,
    output tdd_channel_rise,
    output tdd_channel_fall
  );

endinterface

// File: rtl/axi_tdd_ng_channel_gen.sv
// TDD channel generator.
//
// Sits downstream of the TDD frame counter and produces NUM_CHANNELS timing
// signals. Each channel asserts after its ON count and deasserts after its
// OFF count inside every frame. ON/OFF values are shadowed so that writes
// made mid-frame only take effect from the next frame.
//
// Ports:
//   clk     clock, all logic on posedge
//   resetn  synchronous, active-low reset
//   bus     axi_tdd_ng_channel_gen_if.slave; the interface instance must be
//           parameterised with the same REGISTER_WIDTH / NUM_CHANNELS.
//
// Outputs are registered: a counter value seen in cycle N shows up on
// tdd_channel in cycle N+1. rise/fall track the internal active bit and are
// independent of polarity.

module axi_tdd_ng_channel_gen #(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_CHANNELS   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  axi_tdd_ng_channel_gen_if.slave       bus
);

  import axi_tdd_ng_pkg::*;

  logic [REGISTER_WIDTH-1:0] shadow_on  [NUM_CHANNELS];
  logic [REGISTER_WIDTH-1:0] shadow_off [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   active;
  logic [NUM_CHANNELS-1:0]   active_next;
  logic [NUM_CHANNELS-1:0]   channel_q;
  logic [NUM_CHANNELS-1:0]   rise_q;
  logic [NUM_CHANNELS-1:0]   fall_q;

  logic running;
  logic load_shadow;

  // Shadows follow the live registers whenever the counter is not running,
  // and otherwise refresh only on the last count of a frame so the new
  // values govern the frame starting at count 0.
  always_comb begin
    running     = bus.tdd_enable && (bus.tdd_cstate == RUNNING);
    load_shadow = (bus.tdd_cstate != RUNNING) || bus.tdd_endof_frame;
  end

  // OFF is tested before ON so that ON == OFF never asserts the channel.
  // Matches use the currently held shadow values, so on the end-of-frame
  // cycle the outgoing frame's settings still apply.
  always_comb begin
    active_next = active;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (!running || !bus.tdd_channel_en[i]) begin
        active_next[i] = 1'b0;
      end else if (bus.tdd_counter == shadow_off[i]) begin
        active_next[i] = 1'b0;
      end else if (bus.tdd_counter == shadow_on[i]) begin
        active_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active    <= '0;
      channel_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        shadow_on[i]  <= '0;
        shadow_off[i] <= '0;
      end
    end else begin
      active    <= active_next;
      channel_q <= active_next ^ bus.tdd_channel_pol;
      rise_q    <= ~active & active_next;
      fall_q    <= active & ~active_next;
      if (load_shadow) begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          shadow_on[i]  <= bus.tdd_channel_on[i*REGISTER_WIDTH +: REGISTER_WIDTH];
          shadow_off[i] <= bus.tdd_channel_off[i*REGISTER_WIDTH +: REGISTER_WIDTH];
        end
      end
    end
  end

  always_comb begin
    bus.tdd_channel      = channel_q;
    bus.tdd_channel_rise = rise_q;
    bus.tdd_channel_fall = fall_q;
  end

endmodule
